// File: rtl/wca_rbus_arbiter.sv
// -----------------------------------------------------------------------------
// wca_rbus_arbiter
//
// Two-requester round-robin arbiter and sequencer for the internal register bus.
// Requester 0 is the host DMA bridge and requester 1 is an internal master.
// Each granted single-word read or write is run as four bus phases:
//   IDLE -> ADDR (1 cycle) -> STRB (STROBE_CYCLES cycles) -> DONE (1 cycle) -> IDLE
// The block then returns read data and a one-cycle ack to the winner.
//
// Ports
//   cpuclock     block clock, also forwarded combinationally on rbusCtrl[0]
//   reset        synchronous active-high reset
//   req[1:0]     per-requester request level
//   we[1:0]      per-requester write enable (1 = write, 0 = read)
//   addr0/addr1  per-requester 8-bit register address
//   wdata0/1     per-requester 16-bit write data
//   ack[1:0]     one-cycle completion pulse to the granted requester
//   rdata        read data, valid with ack and held afterwards
//   grant[1:0]   one-hot owner of the current transaction, 0 when idle
//   busy         high whenever the sequencer is not idle
//   rbusCtrl     {0, addr[7:0], nAddrStrobe, nReadStrobe, nWriteStrobe, cpuclock}
//   rbusDataOut  write data driven onto rbusData
//   rbusDataOe   tristate enable for rbusData (applied at top level)
//   rbusDataIn   rbusData as read back from the bus
// -----------------------------------------------------------------------------
module wca_rbus_arbiter #(
    parameter int unsigned STROBE_CYCLES = 2   // strobe low time, 1..15
) (
    input  logic        cpuclock,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [7:0]  addr0,
    input  logic [7:0]  addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic [1:0]  ack,
    output logic [15:0] rdata,
    output logic [1:0]  grant,
    output logic        busy,
    output logic [12:0] rbusCtrl,
    output logic [15:0] rbusDataOut,
    output logic        rbusDataOe,
    input  logic [15:0] rbusDataIn
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_STRB = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // The counter is loaded on entry to STRB and counts down to zero, so the
    // strobe stays low for exactly STROBE_CYCLES cycles.
    localparam logic [3:0] STRB_LOAD = 4'(STROBE_CYCLES - 1);

    state_e      state_q, state_d;
    logic        last_q,  last_d;    // requester that won most recently
    logic        we_q,    we_d;      // latched direction of the current transfer
    logic [3:0]  cnt_q,   cnt_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  ack_q,   ack_d;
    logic [15:0] rdata_q, rdata_d;
    logic        busy_q,  busy_d;
    logic [7:0]  addr_q,  addr_d;    // bus address, latched at grant
    logic        nas_q,   nas_d;
    logic        nrs_q,   nrs_d;
    logic        nws_q,   nws_d;
    logic [15:0] dout_q,  dout_d;
    logic        oe_q,    oe_d;

    logic        win;                // index of the requester chosen in IDLE
    logic        win_we;

    // Next-state and registered-output logic. Outputs are computed for the
    // state being entered, so every bus pin comes straight from a flop.
    always_comb begin
        // NOTE: every value written here gets a default first, so no path through the case can infer a latch.
        state_d = state_q;
        last_d  = last_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        ack_d   = 2'b00;
        rdata_d = rdata_q;
        busy_d  = busy_q;
        addr_d  = addr_q;
        nas_d   = nas_q;
        nrs_d   = nrs_q;
        nws_d   = nws_q;
        dout_d  = dout_q;
        oe_d    = oe_q;
        win     = 1'b0;
        win_we  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    // On contention the requester that did not win last time goes first.
                    win     = (req == 2'b11) ? ~last_q : req[1];
                    win_we  = we[win];
                    state_d = ST_ADDR;
                    last_d  = win;
                    we_d    = win_we;
                    grant_d = win ? 2'b10 : 2'b01;
                    busy_d  = 1'b1;
                    addr_d  = win ? addr1 : addr0;
                    nas_d   = 1'b0;
                    if (win_we) begin
                        dout_d = win ? wdata1 : wdata0;
                        oe_d   = 1'b1;
                    end
                end
            end

            ST_ADDR: begin
                state_d = ST_STRB;
                cnt_d   = STRB_LOAD;
                nas_d   = 1'b1;
                if (we_q) nws_d = 1'b0;
                else      nrs_d = 1'b0;
            end

            ST_STRB: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                    nrs_d   = 1'b1;
                    nws_d   = 1'b1;
                    oe_d    = 1'b0;
                    ack_d   = grant_q;
                    // Read data is sampled on the edge that ends the strobe.
                    if (!we_q) rdata_d = rbusDataIn;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
                busy_d  = 1'b0;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all flops see the same pre-edge values.
    always_ff @(posedge cpuclock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            cnt_q   <= 4'd0;
            grant_q <= 2'b00;
            ack_q   <= 2'b00;
            rdata_q <= 16'h0000;
            busy_q  <= 1'b0;
            addr_q  <= 8'h00;
            nas_q   <= 1'b1;
            nrs_q   <= 1'b1;
            nws_q   <= 1'b1;
            dout_q  <= 16'h0000;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
            nas_q   <= nas_d;
            nrs_q   <= nrs_d;
            nws_q   <= nws_d;
            dout_q  <= dout_d;
            oe_q    <= oe_d;
        end
    end

    assign ack         = ack_q;
    assign rdata       = rdata_q;
    assign grant       = grant_q;
    assign busy        = busy_q;
    assign rbusDataOut = dout_q;
    assign rbusDataOe  = oe_q;
    assign rbusCtrl    = {1'b0, addr_q, nas_q, nrs_q, nws_q, cpuclock};

endmodule

// File: tb/tb_wca_rbus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wca_rbus_arbiter
//
// Bench for wca_rbus_arbiter. One instance uses the default strobe width, a
// second instance uses STROBE_CYCLES=5. Completed transactions on the default
// instance are checked against a queue of expected {ack, rdata} entries that
// the tests push when they issue a request.
// -----------------------------------------------------------------------------
module tb_wca_rbus_arbiter;

    typedef struct {
        logic [1:0]  grant;
        logic [15:0] rdata;
    } exp_t;

    logic        cpuclock = 1'b0;
    logic        reset    = 1'b1;

    // Default instance signals
    logic [1:0]  req = '0, we = '0;
    logic [7:0]  addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0, rbusDataIn = '0;
    logic [1:0]  ack, grant;
    logic [15:0] rdata, rbusDataOut;
    logic        busy, rbusDataOe;
    logic [12:0] rbusCtrl;

    // STROBE_CYCLES=5 instance signals
    logic [1:0]  req5 = '0, we5 = '0;
    logic [7:0]  addr05 = '0, addr15 = '0;
    logic [15:0] wdata05 = '0, wdata15 = '0, rbusDataIn5 = '0;
    logic [1:0]  ack5, grant5;
    logic [15:0] rdata5, rbusDataOut5;
    logic        busy5, rbusDataOe5;
    logic [12:0] rbusCtrl5;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 cpuclock = ~cpuclock;

    wca_rbus_arbiter dut (
        .cpuclock(cpuclock), .reset(reset), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack(ack), .rdata(rdata), .grant(grant), .busy(busy),
        .rbusCtrl(rbusCtrl), .rbusDataOut(rbusDataOut), .rbusDataOe(rbusDataOe),
        .rbusDataIn(rbusDataIn)
    );

    wca_rbus_arbiter #(.STROBE_CYCLES(5)) dut5 (
        .cpuclock(cpuclock), .reset(reset), .req(req5), .we(we5),
        .addr0(addr05), .addr1(addr15), .wdata0(wdata05), .wdata1(wdata15),
        .ack(ack5), .rdata(rdata5), .grant(grant5), .busy(busy5),
        .rbusCtrl(rbusCtrl5), .rbusDataOut(rbusDataOut5), .rbusDataOe(rbusDataOe5),
        .rbusDataIn(rbusDataIn5)
    );

    // Scoreboard consumer: every ack pulse must match the oldest expected entry.
    always @(negedge cpuclock) begin
        if (ack !== 2'b00) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected_ack: got ack=%b, expected no ack", ack);
            end else begin
                mon_e = sb_q.pop_front();
                if (ack !== mon_e.grant || rdata !== mon_e.rdata) begin
                    n_bad++;
                    $display("FAIL sb_ack_rdata: got ack=%b rdata=%h, expected ack=%b rdata=%h",
                             ack, rdata, mon_e.grant, mon_e.rdata);
                end
            end
        end
    end

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge cpuclock);
        #1;
    endtask

    // Advance until an ack appears on the default instance, bounded.
    task automatic wait_ack_bounded();
        int c = 0;
        do begin
            cyc();
            c++;
        end while (ack === 2'b00 && c < 12);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        n_cmp++; if (rbusCtrl[12:1] !== 12'b0_00000000_111) begin n_bad++; $display("FAIL reset_ctrl: got %b, expected %b", rbusCtrl[12:1], 12'b0_00000000_111); end
        n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL reset_grant: got %b, expected 00", grant); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        n_cmp++; if (ack !== 2'b00) begin n_bad++; $display("FAIL reset_ack: got %b, expected 00", ack); end
        n_cmp++; if (rbusDataOe !== 1'b0 || rbusDataOut !== 16'h0000) begin n_bad++; $display("FAIL reset_data: got oe=%b out=%h, expected oe=0 out=0000", rbusDataOe, rbusDataOut); end
        n_cmp++; if (rdata !== 16'h0000) begin n_bad++; $display("FAIL reset_rdata: got %h, expected 0000", rdata); end
        n_cmp++; if (rbusCtrl[0] !== cpuclock) begin n_bad++; $display("FAIL clk_passthru: got %b, expected %b", rbusCtrl[0], cpuclock); end
    endtask

    task automatic test_single_write();
        req = 2'b01; we = 2'b01; addr0 = 8'h2A; wdata0 = 16'hBEEF;
        sb_q.push_back('{grant: 2'b01, rdata: 16'h0000});
        cyc();                       // ADDR cycle
        req = 2'b00;                 // dropping req mid-transaction must not matter
        n_cmp++; if (rbusCtrl[11:1] !== {8'h2A, 3'b011}) begin n_bad++; $display("FAIL wr_addr_phase: got %b, expected %b", rbusCtrl[11:1], {8'h2A, 3'b011}); end
        n_cmp++; if (rbusDataOe !== 1'b1 || rbusDataOut !== 16'hBEEF) begin n_bad++; $display("FAIL wr_addr_data: got oe=%b out=%h, expected oe=1 out=beef", rbusDataOe, rbusDataOut); end
        n_cmp++; if (grant !== 2'b01 || busy !== 1'b1) begin n_bad++; $display("FAIL wr_grant: got grant=%b busy=%b, expected 01/1", grant, busy); end
        for (int i = 0; i < 2; i++) begin
            cyc();                   // STRB cycles
            n_cmp++; if (rbusCtrl[11:1] !== {8'h2A, 3'b110} || rbusDataOe !== 1'b1 || rbusDataOut !== 16'hBEEF || ack !== 2'b00) begin
                n_bad++; $display("FAIL wr_strobe[%0d]: got ctrl=%b oe=%b out=%h ack=%b, expected ctrl=%b oe=1 out=beef ack=00", i, rbusCtrl[11:1], rbusDataOe, rbusDataOut, ack, {8'h2A, 3'b110});
            end
        end
        cyc();                       // DONE cycle
        n_cmp++; if (ack !== 2'b01 || rbusCtrl[3:1] !== 3'b111 || rbusDataOe !== 1'b0) begin n_bad++; $display("FAIL wr_done: got ack=%b strb=%b oe=%b, expected 01/111/0", ack, rbusCtrl[3:1], rbusDataOe); end
        cyc();                       // back in IDLE
        n_cmp++; if (grant !== 2'b00 || busy !== 1'b0 || ack !== 2'b00) begin n_bad++; $display("FAIL wr_idle: got grant=%b busy=%b ack=%b, expected 00/0/00", grant, busy, ack); end
    endtask

    task automatic test_single_read();
        req = 2'b10; we = 2'b00; addr1 = 8'h05; rbusDataIn = 16'h1234;
        sb_q.push_back('{grant: 2'b10, rdata: 16'h1234});
        cyc();                       // ADDR
        n_cmp++; if (rbusCtrl[11:1] !== {8'h05, 3'b011} || rbusDataOe !== 1'b0 || grant !== 2'b10) begin n_bad++; $display("FAIL rd_addr_phase: got ctrl=%b oe=%b grant=%b, expected %b/0/10", rbusCtrl[11:1], rbusDataOe, grant, {8'h05, 3'b011}); end
        addr1 = 8'hFF; we = 2'b10;   // requests are latched at grant
        for (int i = 0; i < 2; i++) begin
            cyc();
            n_cmp++; if (rbusCtrl[11:1] !== {8'h05, 3'b101} || rbusDataOe !== 1'b0) begin n_bad++; $display("FAIL rd_strobe[%0d]: got ctrl=%b oe=%b, expected %b/0", i, rbusCtrl[11:1], rbusDataOe, {8'h05, 3'b101}); end
        end
        cyc();                       // DONE
        req = 2'b00; we = 2'b00;
        n_cmp++; if (ack !== 2'b10 || rdata !== 16'h1234) begin n_bad++; $display("FAIL rd_done: got ack=%b rdata=%h, expected 10/1234", ack, rdata); end
        cyc();
        n_cmp++; if (rdata !== 16'h1234 || busy !== 1'b0) begin n_bad++; $display("FAIL rd_hold: got rdata=%h busy=%b, expected 1234/0", rdata, busy); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] w;
        req = 2'b11; we = 2'b00; rbusDataIn = 16'hC000;
        for (int i = 0; i < 4; i++) begin
            w = (i % 2 == 0) ? 2'b01 : 2'b10;
            sb_q.push_back('{grant: w, rdata: 16'hC000 + 16'(i)});
            wait_ack_bounded();
            n_cmp++; if (ack !== w || grant !== w) begin n_bad++; $display("FAIL contention[%0d]: got ack=%b grant=%b, expected %b", i, ack, grant, w); end
            req = req & ~w;          // winner drops req on seeing ack
            cyc();                   // IDLE
            n_cmp++; if (grant !== 2'b00 || busy !== 1'b0) begin n_bad++; $display("FAIL contention_idle[%0d]: got grant=%b busy=%b, expected 00/0", i, grant, busy); end
            rbusDataIn = 16'hC000 + 16'(i + 1);
            req = (i == 3) ? 2'b00 : 2'b11;
        end
        cyc();
    endtask

    task automatic test_write_rdata_hold();
        req = 2'b01; we = 2'b01; addr0 = 8'h10; wdata0 = 16'h5555;
        sb_q.push_back('{grant: 2'b01, rdata: 16'hC003});
        wait_ack_bounded();
        req = 2'b00; we = 2'b00;
        n_cmp++; if (ack !== 2'b01 || rdata !== 16'hC003) begin n_bad++; $display("FAIL wr_keeps_rdata: got ack=%b rdata=%h, expected 01/c003", ack, rdata); end
        cyc();
    endtask

    task automatic test_reset_mid_strb();
        req = 2'b01; we = 2'b01; addr0 = 8'h33; wdata0 = 16'h0F0F;
        cyc();                       // ADDR
        req = 2'b00; we = 2'b00;
        cyc();                       // first STRB cycle
        n_cmp++; if (rbusCtrl[1] !== 1'b0) begin n_bad++; $display("FAIL mid_nws_low: got %b, expected 0", rbusCtrl[1]); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        n_cmp++; if (rbusCtrl[12:1] !== 12'b0_00000000_111 || rbusDataOe !== 1'b0 || rbusDataOut !== 16'h0000) begin n_bad++; $display("FAIL mid_reset_bus: got ctrl=%b oe=%b out=%h, expected 000000000111/0/0000", rbusCtrl[12:1], rbusDataOe, rbusDataOut); end
        n_cmp++; if (grant !== 2'b00 || busy !== 1'b0 || ack !== 2'b00) begin n_bad++; $display("FAIL mid_reset_ctl: got grant=%b busy=%b ack=%b, expected 00/0/00", grant, busy, ack); end
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_cmp++; if (ack !== 2'b00 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset_quiet[%0d]: got ack=%b busy=%b, expected 00/0", i, ack, busy); end
        end
        req = 2'b10; we = 2'b00; addr1 = 8'h44; rbusDataIn = 16'h7777;
        sb_q.push_back('{grant: 2'b10, rdata: 16'h7777});
        wait_ack_bounded();
        req = 2'b00;
        n_cmp++; if (ack !== 2'b10 || rdata !== 16'h7777) begin n_bad++; $display("FAIL after_reset_read: got ack=%b rdata=%h, expected 10/7777", ack, rdata); end
        cyc();
    endtask

    task automatic test_strobe5();
        logic       exp_nws;
        logic [1:0] exp_ack;
        req5 = 2'b01; we5 = 2'b01; addr05 = 8'h77; wdata05 = 16'h1357;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            if (c == 1) begin
                req5 = 2'b00;
                n_cmp++; if (rbusCtrl5[11:3] !== {8'h77, 1'b0} || rbusDataOut5 !== 16'h1357) begin n_bad++; $display("FAIL s5_addr: got %b out=%h, expected %b/1357", rbusCtrl5[11:3], rbusDataOut5, {8'h77, 1'b0}); end
            end
            exp_nws = (c >= 2 && c <= 6) ? 1'b0 : 1'b1;
            exp_ack = (c == 7) ? 2'b01 : 2'b00;
            n_cmp++; if (rbusCtrl5[1] !== exp_nws || ack5 !== exp_ack) begin n_bad++; $display("FAIL s5_cycle[%0d]: got nws=%b ack=%b, expected nws=%b ack=%b", c, rbusCtrl5[1], ack5, exp_nws, exp_ack); end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_write_rdata_hold();
        test_reset_mid_strb();
        test_strobe5();
        cyc();
        n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL sb_leftover: got %0d pending, expected 0", sb_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
